vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter MAX_CREDIT, default 8'd99, meaning the credit ceiling in coin units.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd1000, meaning idle cycles in COLLECT before auto-refund.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port coin_valid  input  1  one-cycle coin insertion strobe.
REQ-006 SHALL have port coin_value  input  8  value of the inserted coin.
REQ-007 SHALL have port item_req_valid  input  1  one-cycle purchase request strobe.
REQ-008 SHALL have port item_req_sel  input  2  requested item.
REQ-009 SHALL have port cancel  input  1  one-cycle refund request.
REQ-010 SHALL have port price_in  input  8  price of sel_item from the price stage, combinational.
REQ-011 SHALL have port stock_level  input  4  stock of sel_item from the inventory stage.
REQ-012 SHALL have port dispense_ready  input  1  dispenser accepts the item.
REQ-013 SHALL have port change_ready  input  1  coin hopper accepts the change.
REQ-014 SHALL have port sel_item  output  2  registered item index driven to the price stage.
REQ-015 SHALL have port credit  output  8  current credit.
REQ-016 SHALL have port dispense_valid / dispense_item  output  1/2  dispense handshake.
REQ-017 SHALL have port change_valid / change_amount  output  1/8  change handshake.
REQ-018 SHALL have port coin_reject, sold_out, insufficient  output  1 each  one-cycle event pulses.

Function
REQ-019 FSM SHALL have states IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
REQ-020 IDLE: credit is 0; coin_valid adds coin_value and moves to COLLECT; item_req_valid and cancel are ignored.
REQ-021 COLLECT input priority SHALL be cancel > coin_valid > item_req_valid; the lower-priority inputs are dropped in the same cycle.
REQ-022 COLLECT coin: if credit+coin_value exceeds MAX_CREDIT (9-bit compare), credit is unchanged and coin_reject pulses; otherwise credit increases by coin_value.
REQ-023 COLLECT item_req_valid: sel_item <= item_req_sel, then move to CHECK.
REQ-024 COLLECT cancel: move to CHANGE.
REQ-025 CHECK SHALL last exactly one cycle and evaluate price_in and stock_level for the registered sel_item.
REQ-026 CHECK, stock_level==0: sold_out pulses, return to COLLECT.
REQ-027 CHECK, credit<price_in: insufficient pulses, return to COLLECT.
REQ-028 CHECK otherwise: credit <= credit-price_in, move to DISPENSE.
REQ-029 DISPENSE: dispense_valid=1 and dispense_item=sel_item, both held stable until dispense_ready; on handshake, go to CHANGE if credit>0, else IDLE.
REQ-030 CHANGE: change_valid=1 and change_amount=credit, held until change_ready; on handshake, credit <= 0 and go to IDLE.
REQ-031 Any coin_valid in CHECK, DISPENSE or CHANGE SHALL pulse coin_reject and leave credit unchanged; cancel and item_req_valid are ignored in those states.
REQ-032 Event pulses SHALL be registered and assert the cycle after the causing input or evaluation.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, credit 0, sel_item 0, all valids and pulses 0, change_amount 0, and timer 0, including mid-handshake.

Configuration
REQ-034 With VEND_TIMEOUT_EN defined, COLLECT SHALL count cycles with no coin_valid and no item_req_valid, clear the count on either, and move to CHANGE when the count reaches TIMEOUT_CYCLES.
REQ-035 Without VEND_TIMEOUT_EN, there SHALL be no timer logic and credit SHALL be held in COLLECT indefinitely.

Structure
REQ-036 Package vend_pkg SHALL hold the state enum, the credit width constant, and the item index width.
REQ-037 The inactivity counter SHALL be sub-module vend_timeout_timer (inputs clear and enable, output expired), instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-038 Insert 5 then 3, request item 1 at price 5 with stock 4: one dispense of item 1, then change_amount 3, then IDLE with credit 0.
REQ-039 Insert 4, request item 3 at price 8 (low-stock price): insufficient pulses, credit stays 4, state returns to COLLECT.
REQ-040 Request with stock_level 0: sold_out pulses and no dispense_valid.
REQ-041 Credit 95 plus coin 10: coin_reject pulses and credit stays 95; coin during DISPENSE is also rejected.
REQ-042 Hold dispense_ready low for 20 cycles: dispense_valid and dispense_item stay stable; assert rst_n low mid-wait and all outputs clear asynchronously.
REQ-043 With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8, insert 6 then stay idle: change_amount 6 appears after 8 cycles; without the macro, no change appears after 100 cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and widths for the vending controller and its helpers.
package vend_pkg;

    localparam int CREDIT_W = 8;
    localparam int ITEM_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE
    } state_e;

    // Widened to CREDIT_W+1 bits so a wrapping sum can never sneak under the ceiling.
    function automatic logic over_ceiling(input logic [CREDIT_W-1:0] credit,
                                          input logic [CREDIT_W-1:0] coin,
                                          input logic [CREDIT_W-1:0] ceiling);
        return ({1'b0, credit} + {1'b0, coin}) > {1'b0, ceiling};
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity counter for COLLECT; only instantiated when VEND_TIMEOUT_EN is defined.
module vend_timeout_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_q;

    assign expired = (count_q == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin collection, price/stock check, dispense and change handshakes.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] MAX_CREDIT     = 8'd99,
    parameter logic [15:0]         TIMEOUT_CYCLES = 16'd1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                item_req_valid,
    input  logic [ITEM_W-1:0]   item_req_sel,
    input  logic                cancel,
    input  logic [CREDIT_W-1:0] price_in,
    input  logic [3:0]          stock_level,
    input  logic                dispense_ready,
    input  logic                change_ready,
    output logic [ITEM_W-1:0]   sel_item,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_valid,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                insufficient
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ITEM_W-1:0]   sel_q, sel_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;
    logic                insufficient_q, insufficient_d;
    logic                timeout_fire;

`ifdef VEND_TIMEOUT_EN
    vend_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (coin_valid || item_req_valid || (state_q != ST_COLLECT)),
        .enable  (state_q == ST_COLLECT),
        .expired (timeout_fire)
    );
`else
    // No timer is built; the parameter stays for a uniform interface across builds.
    assign timeout_fire = 1'b0 && (TIMEOUT_CYCLES != 16'd0);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        coin_reject_d  = 1'b0;
        sold_out_d     = 1'b0;
        insufficient_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (coin_valid) begin
                    credit_d = coin_value;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    state_d = ST_CHANGE;
                end else if (coin_valid) begin
                    if (over_ceiling(credit_q, coin_value, MAX_CREDIT)) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = credit_q + coin_value;
                    end
                end else if (item_req_valid) begin
                    sel_d   = item_req_sel;
                    state_d = ST_CHECK;
                end else if (timeout_fire) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_CHECK: begin
                if (stock_level == 4'd0) begin
                    sold_out_d = 1'b1;
                    state_d    = ST_COLLECT;
                end else if (credit_q < price_in) begin
                    insufficient_d = 1'b1;
                    state_d        = ST_COLLECT;
                end else begin
                    credit_d = credit_q - price_in;
                    state_d  = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (dispense_ready) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Coins arriving while a transaction is in flight are bounced back.
        if (coin_valid && (state_q inside {ST_CHECK, ST_DISPENSE, ST_CHANGE})) begin
            coin_reject_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            sel_q          <= '0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
            insufficient_q <= insufficient_d;
        end
    end

    assign sel_item       = sel_q;
    assign credit         = credit_q;
    assign dispense_valid = (state_q == ST_DISPENSE);
    assign dispense_item  = sel_q;
    assign change_valid   = (state_q == ST_CHANGE);
    assign change_amount  = change_valid ? credit_q : '0;
    assign coin_reject    = coin_reject_q;
    assign sold_out       = sold_out_q;
    assign insufficient   = insufficient_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a scoreboard of expected dispenses and change.
module tb_vend_controller;

`ifdef VEND_TIMEOUT_EN
    localparam logic [15:0] TO_CYCLES = 16'd8;
`else
    localparam logic [15:0] TO_CYCLES = 16'd1000;
`endif

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       item_req_valid;
    logic [1:0] item_req_sel;
    logic       cancel;
    logic [7:0] price_in;
    logic [3:0] stock_level;
    logic       dispense_ready;
    logic       change_ready;
    logic [1:0] sel_item;
    logic [7:0] credit;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       sold_out;
    logic       insufficient;

    logic [7:0] price_tab [4];
    logic [3:0] stock_tab [4];

    logic [1:0] disp_q [$];
    logic [7:0] chg_q  [$];

    int n_checks = 0;
    int n_pass   = 0;

    vend_controller #(
        .MAX_CREDIT     (8'd99),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .item_req_valid (item_req_valid),
        .item_req_sel   (item_req_sel),
        .cancel         (cancel),
        .price_in       (price_in),
        .stock_level    (stock_level),
        .dispense_ready (dispense_ready),
        .change_ready   (change_ready),
        .sel_item       (sel_item),
        .credit         (credit),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .coin_reject    (coin_reject),
        .sold_out       (sold_out),
        .insufficient   (insufficient)
    );

    // Price and inventory stages: combinational lookups on the registered selection.
    assign price_in    = price_tab[sel_item];
    assign stock_level = stock_tab[sel_item];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic request(input logic [1:0] sel);
        item_req_valid = 1'b1;
        item_req_sel   = sel;
        tick();
        item_req_valid = 1'b0;
        item_req_sel   = '0;
    endtask

    task automatic expect_dispense(input string tag);
        int n = 0;
        logic [1:0] exp;
        while (dispense_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_dvalid"}, 16'(dispense_valid), 16'd1);
        exp = (disp_q.size() > 0) ? disp_q.pop_front() : 2'bxx;
        check({tag, "_ditem"}, 16'(dispense_item), 16'(exp));
        dispense_ready = 1'b1;
        tick();
        dispense_ready = 1'b0;
    endtask

    task automatic expect_change(input string tag);
        int n = 0;
        logic [7:0] exp;
        while (change_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_cvalid"}, 16'(change_valid), 16'd1);
        exp = (chg_q.size() > 0) ? chg_q.pop_front() : 8'hxx;
        check({tag, "_camount"}, 16'(change_amount), 16'(exp));
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
    endtask

    initial begin
        int seen;
        price_tab[0] = 8'd10; stock_tab[0] = 4'd5;
        price_tab[1] = 8'd5;  stock_tab[1] = 4'd4;
        price_tab[2] = 8'd3;  stock_tab[2] = 4'd0;
        price_tab[3] = 8'd8;  stock_tab[3] = 4'd1;
        rst_n = 1'b0;
        coin_valid = 1'b0; coin_value = '0;
        item_req_valid = 1'b0; item_req_sel = '0;
        cancel = 1'b0; dispense_ready = 1'b0; change_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_credit", 16'(credit), 16'd0);
        check("rst_sel", 16'(sel_item), 16'd0);
        check("rst_dvalid", 16'(dispense_valid), 16'd0);
        check("rst_cvalid", 16'(change_valid), 16'd0);

        // IDLE ignores cancel and item requests
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("idle_cancel", 16'(change_valid), 16'd0);
        request(2'd3);
        check("idle_req_sel", 16'(sel_item), 16'd0);

        // 5 + 3, buy item 1 at 5 -> dispense 1, change 3
        insert_coin(8'd5);
        check("buy_credit5", 16'(credit), 16'd5);
        insert_coin(8'd3);
        check("buy_credit8", 16'(credit), 16'd8);
        disp_q.push_back(2'd1);
        chg_q.push_back(8'd3);
        request(2'd1);
        check("buy_sel", 16'(sel_item), 16'd1);
        tick();
        check("buy_credit3", 16'(credit), 16'd3);
        expect_dispense("buy");
        expect_change("buy");
        check("buy_end_credit", 16'(credit), 16'd0);
        check("buy_end_cvalid", 16'(change_valid), 16'd0);

        // Insufficient credit, then cancel beats coin and request in the same cycle
        insert_coin(8'd4);
        request(2'd3);
        tick();
        check("insuf_pulse", 16'(insufficient), 16'd1);
        check("insuf_credit", 16'(credit), 16'd4);
        check("insuf_dvalid", 16'(dispense_valid), 16'd0);
        tick();
        check("insuf_pulse_end", 16'(insufficient), 16'd0);
        chg_q.push_back(8'd4);
        cancel = 1'b1; coin_valid = 1'b1; coin_value = 8'd1;
        item_req_valid = 1'b1; item_req_sel = 2'd0;
        tick();
        cancel = 1'b0; coin_valid = 1'b0; coin_value = '0; item_req_valid = 1'b0;
        check("prio_cancel_noreject", 16'(coin_reject), 16'd0);
        expect_change("cancel");

        // Coin beats request; then sold-out item
        insert_coin(8'd5);
        coin_valid = 1'b1; coin_value = 8'd2;
        item_req_valid = 1'b1; item_req_sel = 2'd2;
        tick();
        coin_valid = 1'b0; coin_value = '0; item_req_valid = 1'b0;
        check("prio_coin_credit", 16'(credit), 16'd7);
        check("prio_coin_sel", 16'(sel_item), 16'd3);
        request(2'd2);
        tick();
        check("soldout_pulse", 16'(sold_out), 16'd1);
        check("soldout_credit", 16'(credit), 16'd7);
        seen = 0;
        repeat (4) begin
            if (dispense_valid === 1'b1) seen++;
            tick();
        end
        check("soldout_no_dispense", 16'(seen), 16'd0);
        chg_q.push_back(8'd7);
        cancel = 1'b1; tick(); cancel = 1'b0;
        expect_change("soldout");

        // Credit ceiling and coins during DISPENSE
        insert_coin(8'd50);
        insert_coin(8'd45);
        check("ceil_credit95", 16'(credit), 16'd95);
        insert_coin(8'd10);
        check("ceil_reject", 16'(coin_reject), 16'd1);
        check("ceil_credit_kept", 16'(credit), 16'd95);
        insert_coin(8'd4);
        check("ceil_exact_noreject", 16'(coin_reject), 16'd0);
        check("ceil_credit99", 16'(credit), 16'd99);
        disp_q.push_back(2'd0);
        chg_q.push_back(8'd89);
        request(2'd0);
        tick();
        check("disp_credit89", 16'(credit), 16'd89);
        insert_coin(8'd7);
        check("disp_coin_reject", 16'(coin_reject), 16'd1);
        check("disp_coin_credit", 16'(credit), 16'd89);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("disp_cancel_ignored", 16'(dispense_valid), 16'd1);
        expect_dispense("ceil");
        expect_change("ceil");

        // Dispense stall, then asynchronous reset mid-handshake
        insert_coin(8'd9);
        disp_q.push_back(2'd1);
        request(2'd1);
        tick();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (dispense_valid !== 1'b1 || dispense_item !== 2'd1) seen++;
            if (i == 9) coin_valid = 1'b1;
            tick();
            coin_valid = 1'b0;
            if (i == 9) begin
                check("stall_stable", 16'(seen), 16'd0);
                check("stall_coin_reject", 16'(coin_reject), 16'd1);
                #2 rst_n = 1'b0;
                #1;
                check("arst_dvalid", 16'(dispense_valid), 16'd0);
                check("arst_ditem", 16'(dispense_item), 16'd0);
                check("arst_credit", 16'(credit), 16'd0);
                check("arst_reject", 16'(coin_reject), 16'd0);
                check("arst_cvalid", 16'(change_valid), 16'd0);
                check("arst_camount", 16'(change_amount), 16'd0);
                break;
            end
        end
        disp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Inactivity in COLLECT
        insert_coin(8'd6);
`ifdef VEND_TIMEOUT_EN
        chg_q.push_back(8'd6);
        seen = 0;
        while (change_valid !== 1'b1 && seen < 40) begin
            tick();
            seen++;
        end
        check("timeout_latency", 16'(seen), 16'(TO_CYCLES) + 16'd1);
        expect_change("timeout");
`else
        seen = 0;
        repeat (100) begin
            if (change_valid === 1'b1) seen++;
            tick();
        end
        check("no_timeout_change", 16'(seen), 16'd0);
        check("no_timeout_credit", 16'(credit), 16'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
